// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file write port, with a starvation guard for B.
// Optional define REGARB_R0_DROP_EN suppresses the write pulse for transfers to register 0.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned REG_ID_WIDTH = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ReqA_Valid,
  output logic                    ReqA_Ready,
  input  logic [REG_ID_WIDTH-1:0] ReqA_RegId,
  input  logic [DATA_WIDTH-1:0]   ReqA_Data,
  input  logic                    ReqB_Valid,
  output logic                    ReqB_Ready,
  input  logic [REG_ID_WIDTH-1:0] ReqB_RegId,
  input  logic [DATA_WIDTH-1:0]   ReqB_Data,
  output logic                    WriteReg,
  output logic [REG_ID_WIDTH-1:0] RegId,
  output logic [DATA_WIDTH-1:0]   WriteData,
  output logic                    GrantB,
  output logic [3:0]              StarveCnt
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic                    grant_a, grant_b, xfer, issue;
  logic [REG_ID_WIDTH-1:0] win_id;
  logic [DATA_WIDTH-1:0]   win_data;

  logic [3:0]              starve_q, starve_d;
  logic                    write_q, write_d;
  logic [REG_ID_WIDTH-1:0] id_q, id_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    gb_q, gb_d;

  always_comb begin
    grant_b  = ReqB_Valid && (!ReqA_Valid || (starve_q >= Limit));
    grant_a  = ReqA_Valid && !grant_b;
    xfer     = grant_a || grant_b;
    win_id   = grant_b ? ReqB_RegId : ReqA_RegId;
    win_data = grant_b ? ReqB_Data  : ReqA_Data;
`ifdef REGARB_R0_DROP_EN
    // R0 is hardwired zero: the handshake completes but no write is issued.
    issue    = xfer && (win_id != '0);
`else
    issue    = xfer;
`endif
  end

  // Ready is forced low while reset is held so no handshake can complete.
  assign ReqA_Ready = rst_n && grant_a;
  assign ReqB_Ready = rst_n && grant_b;

  always_comb begin
    starve_d = '0;
    if (ReqB_Valid && !grant_b) begin
      starve_d = (starve_q >= Limit) ? Limit : starve_q + 4'd1;
    end
    write_d = issue;
    id_d    = issue ? win_id   : id_q;
    data_d  = issue ? win_data : data_q;
    gb_d    = issue ? grant_b  : gb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      write_q  <= 1'b0;
      id_q     <= '0;
      data_q   <= '0;
      gb_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      write_q  <= write_d;
      id_q     <= id_d;
      data_q   <= data_d;
      gb_q     <= gb_d;
    end
  end

  assign WriteReg  = write_q;
  assign RegId     = id_q;
  assign WriteData = data_q;
  assign GrantB    = gb_q;
  assign StarveCnt = starve_q;

endmodule
